imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory.
- Receives a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory through its write port, at consecutive addresses starting from 0.
- Holds the core (fetch unit PC) in reset-hold until the program image is complete. Replaces hierarchical memory preloading with a synthesizable load path.

Parameters:
IMEM_DEPTH, 64, number of 32-bit words in instruction memory; maximum legal program length
ADDR_W, 6, width of imem_addr; must satisfy 2**ADDR_W >= IMEM_DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle request to begin a new load; ignored while busy
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle (handshake when in_valid && in_ready)
imem_we  output  1  one-cycle instruction memory write strobe
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  instruction word for the write
core_hold  output  1  holds fetch PC at 0 while high
busy  output  1  load in progress
done  output  1  load completed successfully; sticky until next start
err  output  1  illegal length header; sticky until next start
words_loaded  output  ADDR_W+1  count of words written in current or last load

Behaviour:
- Stream format: len_lo, len_hi (16-bit word count N, little-endian), then N words of 4 bytes each, least-significant byte first.
- Reset values (rst_n low at a clock edge):
  - state=IDLE
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - core_hold=1, busy=0, done=0, err=0, words_loaded=0
- Reset mid-load aborts immediately; memory contents already written are left as they are.
- States:
  - IDLE: in_ready=0. start -> LEN_LO; on entry clear done, err and words_loaded, and set core_hold=1.
  - LEN_LO: in_ready=1. On handshake latch the low length byte -> LEN_HI.
  - LEN_HI: in_ready=1. On handshake form N.
    - N==0 or N>IMEM_DEPTH -> ERR.
    - Otherwise -> DATA with byte index=0 and word index=0.
  - DATA: in_ready=1. Each handshake shifts the byte into bit lane [8*idx +: 8] and increments idx (2 bits).
    - On the 4th byte (idx==3), the next cycle has imem_we=1, imem_addr=word index and imem_wdata=the assembled word (including this byte); then words_loaded+1 and word index+1.
    - If that word is word N-1 -> DONE; else remain in DATA with idx wrapping to 0.
  - DONE: in_ready=0, done=1, core_hold=0, busy=0. start -> LEN_LO (re-hold the core).
  - ERR: in_ready=0, err=1, core_hold=1. start -> LEN_LO.
- busy=1 exactly in LEN_LO, LEN_HI and DATA.
- start while busy has no effect.
- start in the same cycle as a byte handshake is impossible, since in_ready=0 in IDLE/DONE/ERR.
- in_valid gaps of any length are tolerated; assembly state is held.
- Bytes offered while in_ready=0 are not consumed.
- Write latency: imem_we is high exactly one cycle after the handshake of the word's 4th byte.
  - in_ready stays 1 during that write cycle, so back-to-back bytes sustain 1 byte/cycle. The next word's first byte may be accepted in the write cycle.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Entry into DONE coincides with the final imem_we pulse; done rises in the same cycle as the last write.

Decomposition:
- Shared package (imem_loader_pkg): state encoding constants (IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR as 3-bit localparams) and BYTES_PER_WORD=4.
- One natural sub-module: byte_word_packer, covering the 2-bit byte index, the 32-bit shift/lane register and the word_valid pulse with clear.
- imem_loader itself holds the FSM, length check, address counter and write-port registers.

Test Plan:
- Reset, start, then bytes 02 00 33 01 10 00 B3 01 10 40 back-to-back -> imem_we pulses twice: addr0=0x00100133, addr1=0x401001B3. done=1 and core_hold=0 with the second pulse; words_loaded=2.
- Same image with in_valid low for 3 cycles between every byte -> identical writes and data; in_ready never drops in DATA.
- Header 00 00 -> ERR after LEN_HI: err=1, core_hold=1, no imem_we. Header 41 00 with IMEM_DEPTH=64 -> err=1. A subsequent start plus a valid 1-word image -> err=0, done=1.
- Pulse start while in DATA after 5 bytes -> ignored; load completes normally at the expected address.
- Drive rst_n low for 1 cycle after 6 bytes of a 2-word image -> all outputs return to reset values. A restart with a fresh header writes from addr0.
- Max image, 64 words with data = word index -> 64 writes at addr 0..63 with matching data; words_loaded=64; no write to addr beyond 63.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// stream framing constants and the program-length legality check.
package imem_loader_pkg;

    // FSM state encoding, kept as plain 3-bit constants so checkers can bind
    // to state_q without depending on an enum type.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_DONE   = 3'd4;
    localparam state_t ST_ERR    = 3'd5;

    // Stream framing: each instruction word arrives as 4 bytes, LSB first,
    // after a 16-bit little-endian word-count header.
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    // A program length is legal when it is non-empty and fits in memory.
    function automatic logic len_is_legal(input logic [LEN_W-1:0] n,
                                          input int unsigned      depth);
        logic [31:0] n_ext;
        n_ext = {{(32-LEN_W){1'b0}}, n};
        return (n != '0) && (n_ext <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Byte-to-word packer: places accepted bytes into little-endian byte lanes
// and flags the cycle in which the fourth byte of a word is accepted.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_fire,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_q,   idx_d;
    logic [31:0] lanes_q, lanes_d;

    // Lane insertion and index advance; word/word_valid show the completed
    // word (including the incoming byte) combinationally so the owner of the
    // write port can register it on the same edge the byte is consumed.
    always_comb begin
        idx_d      = idx_q;
        lanes_d    = lanes_q;
        word_valid = 1'b0;
        if (clr) begin
            idx_d   = '0;
            lanes_d = '0;
        end else if (byte_fire) begin
            lanes_d[8*idx_q +: 8] = byte_in;
            idx_d                 = idx_q + 2'd1;
            word_valid            = (idx_q == LAST_IDX);
        end
        word = lanes_d;
    end

    // Byte index and lane register; the index wraps naturally after lane 3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: consumes a length-prefixed byte stream, writes
// little-endian 32-bit words to consecutive imem addresses from 0, and keeps
// the core held in reset until a complete image has been written.
//
// Stream handshake: a byte is transferred on a rising clk edge when both
// in_valid and in_ready are high in the cycle before that edge. in_ready is
// a pure function of the FSM state and never depends on in_valid; in_valid
// may drop at any time without loss of assembly state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] WL_ONE = (ADDR_W+1)'(1);

    state_t            state_q,        state_d;
    logic [7:0]        len_lo_q,       len_lo_d;
    logic [ADDR_W:0]   len_q,          len_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic              imem_we_q,      imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,    imem_addr_d;
    logic [31:0]       imem_wdata_q,   imem_wdata_d;

    logic              byte_fire;
    logic              data_fire;
    logic              start_ok;
    logic              last_word;
    logic [LEN_W-1:0]  len_n;
    logic              word_valid;
    logic [31:0]       packed_word;

    // Handshake and decode helpers shared by the FSM and datapath.
    always_comb begin
        byte_fire = in_valid && in_ready;
        data_fire = byte_fire && (state_q == ST_DATA);
        start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERR));
        len_n     = {in_data, len_lo_q};
        // words_loaded doubles as the index of the word being written.
        last_word = ((words_loaded_q + WL_ONE) == len_q);
    end

    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_ok),
        .byte_fire  (data_fire),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    // State and write-port registers; reset aborts any load in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            len_lo_q       <= '0;
            len_q          <= '0;
            words_loaded_q <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            len_q          <= len_d;
            words_loaded_q <= words_loaded_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
        end
    end

    // Next-state logic: header parse, length check, word counting to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (byte_fire) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (byte_fire) begin
                    if (len_is_legal(len_n, IMEM_DEPTH)) state_d = ST_DATA;
                    else                                 state_d = ST_ERR;
                end
            end
            ST_DATA: begin
                // DONE is entered on the same edge that launches the last write.
                if (word_valid && last_word) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: header latch, word counter and write-port register updates.
    always_comb begin
        len_lo_d       = len_lo_q;
        len_d          = len_q;
        words_loaded_d = words_loaded_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;

        if (start_ok) begin
            words_loaded_d = '0;
        end
        if ((state_q == ST_LEN_LO) && byte_fire) begin
            len_lo_d = in_data;
        end
        // Only lengths up to IMEM_DEPTH are ever used, so the narrow copy
        // is exact whenever the FSM proceeds to DATA.
        if ((state_q == ST_LEN_HI) && byte_fire) begin
            len_d = len_n[ADDR_W:0];
        end
        if (word_valid) begin
            imem_we_d      = 1'b1;
            imem_addr_d    = words_loaded_q[ADDR_W-1:0];
            imem_wdata_d   = packed_word;
            words_loaded_d = words_loaded_q + WL_ONE;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        core_hold = 1'b1;
        case (state_q)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a write scoreboard.
module tb_imem_loader;

  localparam int IMEM_DEPTH = 64;
  localparam int ADDR_W     = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected writes: {addr, data}
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_w;

  logic [7:0] img[$];

  imem_loader #(.IMEM_DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the head of exp_q.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write (t=%0t)",
                 imem_addr, imem_wdata, $time);
      end else begin
        exp_w = exp_q.pop_front();
        check("write_addr", 64'(imem_addr), 64'(exp_w[ADDR_W+31:32]));
        check("write_data", 64'(imem_wdata), 64'(exp_w[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until accepted; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit accepted;
    accepted = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      if (in_ready === 1'b1) accepted = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got in_ready=0 for 50 cycles, expected byte 0x%02h accepted", b);
    end
  endtask

  // Send bytes [first, last] of img with `gap` idle cycles between bytes;
  // optionally check that in_ready stays high during gaps inside DATA.
  task automatic send_range(input int first, input int last, input int gap, input bit chk_gap);
    for (int i = first; i <= last; i++) begin
      send_byte(img[i]);
      if (i < last) begin
        for (int g = 0; g < gap; g++) begin
          if (chk_gap && i >= 2) check("ready_in_gap", 64'(in_ready), 64'd1);
          tick();
        end
      end
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready",     64'(in_ready),     64'd0);
    check("rst_imem_we",      64'(imem_we),      64'd0);
    check("rst_imem_addr",    64'(imem_addr),    64'd0);
    check("rst_imem_wdata",   64'(imem_wdata),   64'd0);
    check("rst_core_hold",    64'(core_hold),    64'd1);
    check("rst_busy",         64'(busy),         64'd0);
    check("rst_done",         64'(done),         64'd0);
    check("rst_err",          64'(err),          64'd0);
    check("rst_words_loaded", 64'(words_loaded), 64'd0);
  endtask

  task automatic load_img_two_words();
    img = '{8'h02, 8'h00, 8'h33, 8'h01, 8'h10, 8'h00, 8'hB3, 8'h01, 8'h10, 8'h40};
  endtask

  task automatic expect_write(input int addr, input logic [31:0] data);
    exp_q.push_back({ADDR_W'(addr), data});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Two-word image, back-to-back bytes
    pulse_start();
    check("t1_busy",      64'(busy),      64'd1);
    check("t1_core_hold", 64'(core_hold), 64'd1);
    check("t1_in_ready",  64'(in_ready),  64'd1);
    load_img_two_words();
    expect_write(0, 32'h00100133);
    expect_write(1, 32'h401001B3);
    send_range(0, 9, 0, 1'b0);
    // Now in the cycle of the final write.
    check("t1_we_last",   64'(imem_we),      64'd1);
    check("t1_done",      64'(done),         64'd1);
    check("t1_core_hold", 64'(core_hold),    64'd0);
    check("t1_busy_end",  64'(busy),         64'd0);
    check("t1_words",     64'(words_loaded), 64'd2);
    tick();
    check("t1_we_low",    64'(imem_we),    64'd0);
    check("t1_addr_hold", 64'(imem_addr),  64'd1);
    check("t1_data_hold", 64'(imem_wdata), 64'h401001B3);
    check("t1_done_stk",  64'(done),       64'd1);

    // Same image with 3-cycle gaps between bytes
    pulse_start();
    check("t2_done_clr",  64'(done),         64'd0);
    check("t2_words_clr", 64'(words_loaded), 64'd0);
    check("t2_core_hold", 64'(core_hold),    64'd1);
    expect_write(0, 32'h00100133);
    expect_write(1, 32'h401001B3);
    send_range(0, 9, 3, 1'b1);
    check("t2_done",  64'(done),         64'd1);
    check("t2_words", 64'(words_loaded), 64'd2);

    // Zero-length header
    pulse_start();
    img = '{8'h00, 8'h00};
    send_range(0, 1, 0, 1'b0);
    check("t3_err",       64'(err),       64'd1);
    check("t3_core_hold", 64'(core_hold), 64'd1);
    check("t3_busy",      64'(busy),      64'd0);
    check("t3_in_ready",  64'(in_ready),  64'd0);
    // Bytes offered while not ready are ignored.
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check("t3_err_stk", 64'(err), 64'd1);

    // Over-length header (65 > 64)
    pulse_start();
    check("t3_err_clr", 64'(err), 64'd0);
    img = '{8'h41, 8'h00};
    send_range(0, 1, 0, 1'b0);
    check("t3_err_65", 64'(err), 64'd1);

    // Recovery with a valid one-word image
    pulse_start();
    check("t3_err_clr2", 64'(err), 64'd0);
    img = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    expect_write(0, 32'h00000013);
    send_range(0, 5, 0, 1'b0);
    check("t3_done",  64'(done),         64'd1);
    check("t3_err_0", 64'(err),          64'd0);
    check("t3_words", 64'(words_loaded), 64'd1);

    // start pulsed mid-DATA is ignored
    pulse_start();
    load_img_two_words();
    expect_write(0, 32'h00100133);
    expect_write(1, 32'h401001B3);
    send_range(0, 4, 0, 1'b0);
    pulse_start();
    check("t4_busy", 64'(busy), 64'd1);
    send_range(5, 9, 0, 1'b0);
    check("t4_done",  64'(done),         64'd1);
    check("t4_words", 64'(words_loaded), 64'd2);

    // Reset after 6 bytes of a 2-word image
    pulse_start();
    load_img_two_words();
    expect_write(0, 32'h00100133);
    send_range(0, 5, 0, 1'b0);
    check("t5_we_w0", 64'(imem_we), 64'd1);
    rst_n = 1'b0;
    tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();
    pulse_start();
    img = '{8'h01, 8'h00, 8'hB3, 8'h01, 8'h10, 8'h40};
    expect_write(0, 32'h401001B3);
    send_range(0, 5, 0, 1'b0);
    check("t5_done",  64'(done),         64'd1);
    check("t5_words", 64'(words_loaded), 64'd1);

    // Maximum image: 64 words, data = index
    pulse_start();
    img = {};
    img.push_back(8'h40);
    img.push_back(8'h00);
    for (int w = 0; w < IMEM_DEPTH; w++) begin
      img.push_back(8'(w));
      img.push_back(8'h00);
      img.push_back(8'h00);
      img.push_back(8'h00);
      expect_write(w, 32'(w));
    end
    send_range(0, img.size() - 1, 0, 1'b0);
    check("t6_done",      64'(done),         64'd1);
    check("t6_words",     64'(words_loaded), 64'd64);
    check("t6_last_addr", 64'(imem_addr),    64'd63);
    tick();
    check("t6_we_low", 64'(imem_we), 64'd0);

    repeat (3) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
